// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instruction_fetch_unit_if                                          |
// | Program-memory, decode-handshake and redirect bundle of the fetch  |
// | unit. master = fetch unit, slave = memory/decode/branch side.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] imem_address;
  logic [DATA_WIDTH-1:0] imem_instruction;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instruction;
  logic [DATA_WIDTH-1:0] out_pc;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  fetch_fault;

  modport master (
    output imem_address, out_valid, out_instruction, out_pc, fetch_fault,
    input  imem_instruction, out_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_address, out_valid, out_instruction, out_pc, fetch_fault,
    output imem_instruction, out_ready, redirect_valid, redirect_target
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instruction_fetch_unit                                             |
// | Fetch PC sequencer with a 2-entry prefetch buffer and redirect     |
// | flush. Optional macro FETCH_BOUNDS_CHECK_EN adds a sticky          |
// | out-of-range fetch fault.                                          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  wire logic                clk,
  input  wire logic                reset,
  instruction_fetch_unit_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] c_align_mask = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] c_pc_step    = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_pc0, r_pc1;
  logic [DATA_WIDTH-1:0] r_ins0, r_ins1;
  logic [1:0]            r_count;
  logic                  r_fault;

  logic                  w_pop;
  logic                  w_room;
  logic                  w_blocked;
  logic                  w_push;
  logic                  w_wr_slot1;
  logic [1:0]            w_count_next;
  logic [DATA_WIDTH-1:0] w_target;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] c_depth = DATA_WIDTH'(MEMORY_DEPTH);
  logic [DATA_WIDTH-1:0] w_offset;
  logic                  w_oob;

  always_comb begin
    w_offset = r_fetch_pc - RESET_PC;
    w_oob    = (w_offset >> 2) >= c_depth;
  end

  // Sticky until a redirect supplies a fresh, possibly in-range, target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_fault <= 1'b0;
    end else if (w_oob) begin
      r_fault <= 1'b1;
    end
  end

  assign w_blocked = r_fault | w_oob;
`else
  assign r_fault   = 1'b0;
  assign w_blocked = 1'b0;
`endif

  // Slot 0 is always the head; slot 1 is the younger entry when count == 2.
  always_comb begin
    w_pop        = (r_count != 2'd0) && bus.out_ready;
    w_room       = (r_count != 2'd2) || w_pop;
    w_push       = w_room && !bus.redirect_valid && !w_blocked;
    w_wr_slot1   = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);
    w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    w_target     = bus.redirect_target & c_align_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= 2'd0;
      r_pc0      <= '0;
      r_pc1      <= '0;
      r_ins0     <= '0;
      r_ins1     <= '0;
    end else if (bus.redirect_valid) begin
      // Slots are left untouched so the outputs keep showing the last head.
      r_count    <= 2'd0;
      r_fetch_pc <= w_target;
    end else begin
      r_count <= w_count_next;
      if (w_pop && (r_count == 2'd2)) begin
        r_pc0  <= r_pc1;
        r_ins0 <= r_ins1;
      end
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + c_pc_step;
        if (w_wr_slot1) begin
          r_pc1  <= r_fetch_pc;
          r_ins1 <= bus.imem_instruction;
        end else begin
          r_pc0  <= r_fetch_pc;
          r_ins0 <= bus.imem_instruction;
        end
      end
    end
  end

  assign bus.imem_address    = r_fetch_pc;
  assign bus.out_valid       = (r_count != 2'd0);
  assign bus.out_pc          = r_pc0;
  assign bus.out_instruction = r_ins0;
  assign bus.fetch_fault     = r_fault;

endmodule
`default_nettype wire
